vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA/video timing generator, the next generation of the fixed 640x480@60 generator. All porch/sync/visible counts, sync polarities, pixel-clock division and the output pipeline delay are configurable. Adds a run/hold enable plus line-start and frame-start strobes. Feeds pixel generators, e.g. the snake renderer, whose pipeline depth is matched via PIPE_DELAY.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low, 1 = active-high)
V_SYNC_POL, 0, vsync active level
CLK_DIV, 1, clocks per pixel (>=1)
PIPE_DELAY, 1, pixel periods of delay on hsync/vsync/display_on relative to pos_x/pos_y (>=0)
CNT_W, 10, width of pos_x/pos_y; H_TOTAL and V_TOTAL must each be <= 2^CNT_W

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset (0 = in reset)
enable  input  1  1 = timing runs; 0 = all state frozen
pix_stb  output  1  one-clock strobe marking each pixel period
pos_x  output  CNT_W  current column, 0..H_TOTAL-1
pos_y  output  CNT_W  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync at configured polarity, delayed
vsync  output  1  vertical sync at configured polarity, delayed
display_on  output  1  visible-region flag, delayed
line_start  output  1  strobe: pixel (0, y) presented this cycle
frame_start  output  1  strobe: pixel (0, 0) presented this cycle

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Derived localparams.
- Reset (async assert, sync release): pos_x=0, pos_y=0, divider=0, every pipe stage loaded with inactive values (hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, display_on=0). pix_stb, line_start, frame_start read 0 while reset is low.
- Divider: counts 0..CLK_DIV-1 while enable=1; pix_stb = enable && divider==CLK_DIV-1. CLK_DIV=1 gives pix_stb=enable every clock.
- Counters advance only on clocks with pix_stb=1: pos_x wraps from H_TOTAL-1 to 0. pos_y increments only at the x wrap, and wraps from V_TOTAL-1 to 0.
- Raw signals, combinational from counters:
  - hs_raw = pos_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC)
  - vs_raw = pos_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC)
  - de_raw = pos_x<H_VISIBLE && pos_y<V_VISIBLE
- Output pipe: PIPE_DELAY register stages, shifting only on pix_stb. Stage input is raw sync XNOR polarity (active level applied before the pipe).
  - PIPE_DELAY=0: outputs are combinational from counters.
  - PIPE_DELAY=N: outputs equal the raw values of the pixel N periods earlier.
- line_start = pix_stb && pos_x==0. frame_start = line_start && pos_y==0. Both are undelayed and aligned with pos_x/pos_y.
- enable=0: divider, counters and pipe all hold; all strobes 0; sync and display_on keep their last values. enable rising resumes from the held state with no skipped pixel.
- Reset mid-frame: immediate return to the reset state. The first pix_stb after release presents (0,0) and asserts frame_start.
- First frame after reset: outputs carry the reset-loaded inactive values for the first PIPE_DELAY pixels, then track the timing.

Test Plan:
- Defaults, CLK_DIV=1, PIPE_DELAY=1, run 2 frames -> 800 clocks between line_start pulses; 420000 clocks between frame_start pulses.
  - hsync low for exactly 96 pixels, beginning at the pixel after pos_x=656 is presented.
  - vsync low for 2 lines, spanning lines 490-491 shifted one pixel.
  - display_on high for 640 consecutive pixels on lines 0..479 only.
- Small config H=8/2/3/2, V=4/1/2/1, CLK_DIV=3, PIPE_DELAY=0 -> pix_stb every 3rd clock; pos_x cycles 0..14; pos_y cycles 0..7.
  - frame_start every 360 clocks.
  - hsync (active-low) low while pos_x is 10..12.
- Same config with H_SYNC_POL=1, V_SYNC_POL=1, PIPE_DELAY=2 -> hsync high for 3 pixels, starting 2 pix_stb after pos_x=10 is presented.
  - vsync high for lines 5..6, delayed by 2 pixels.
  - Immediately after reset, hsync=0 and vsync=0.
- Deassert enable for 7 clocks at pos_x=5 -> pos_x, pos_y, hsync, vsync and display_on are frozen; no strobes.
  - On resume, the next presented pixel is pos_x=6.
- Pull reset low mid-line at pos=(9,3) -> outputs go immediately (async) to (0,0), inactive syncs, display_on=0.
  - After release, the first pix_stb asserts frame_start and line_start.
- Boundary wrap at (H_TOTAL-1, V_TOTAL-1) -> the next pixel is (0,0) with frame_start=1; no out-of-range count ever appears (assertion checked over 3 frames).

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run/hold enable towards the generator, pixel
// position, syncs and strobes back to the pixel pipeline.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic             pix_stb;
  logic [CNT_W-1:0] pos_x;
  logic [CNT_W-1:0] pos_y;
  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  enable,
    output pix_stb, pos_x, pos_y, hsync, vsync, display_on,
           line_start, frame_start
  );

  modport slave (
    output enable,
    input  pix_stb, pos_x, pos_y, hsync, vsync, display_on,
           line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel-clock divider, x/y raster
// counters and a pix_stb-clocked delay pipe on sync/display_on.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_DELAY = 1,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // One extra bit so that region ends equal to 2^CNT_W still compare correctly.
  localparam logic [CNT_W:0] H_VIS_END = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] HS_BEG    = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_VIS_END = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] VS_BEG    = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic HS_ACT = (H_SYNC_POL != 0);
  localparam logic VS_ACT = (V_SYNC_POL != 0);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_pos_x;
  logic [CNT_W-1:0] r_pos_y;

  logic             w_div_last;
  logic             w_pix_stb;
  logic             w_x_last;
  logic             w_y_last;
  logic [CNT_W:0]   w_x_ext;
  logic [CNT_W:0]   w_y_ext;
  logic             w_hs_raw;
  logic             w_vs_raw;
  logic             w_de_raw;
  logic             w_hs_lvl;
  logic             w_vs_lvl;
  logic             w_line_start;

  // Strobe is forced low during reset even though CLK_DIV=1 makes the
  // divider compare permanently true.
  assign w_div_last = (r_div == DIV_LAST);
  assign w_pix_stb  = vid.enable & reset & w_div_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (vid.enable) begin
      r_div <= w_div_last ? '0 : r_div + 1'b1;
    end
  end

  assign w_x_last = (r_pos_x == H_LAST);
  assign w_y_last = (r_pos_y == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else if (w_pix_stb) begin
      if (w_x_last) begin
        r_pos_x <= '0;
        r_pos_y <= w_y_last ? '0 : r_pos_y + 1'b1;
      end else begin
        r_pos_x <= r_pos_x + 1'b1;
      end
    end
  end

  assign w_x_ext  = {1'b0, r_pos_x};
  assign w_y_ext  = {1'b0, r_pos_y};
  assign w_hs_raw = (w_x_ext >= HS_BEG) && (w_x_ext < HS_END);
  assign w_vs_raw = (w_y_ext >= VS_BEG) && (w_y_ext < VS_END);
  assign w_de_raw = (w_x_ext < H_VIS_END) && (w_y_ext < V_VIS_END);

  // Polarity is applied before the pipe so reset can preload inactive levels.
  assign w_hs_lvl = w_hs_raw ? HS_ACT : ~HS_ACT;
  assign w_vs_lvl = w_vs_raw ? VS_ACT : ~VS_ACT;

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign vid.hsync      = w_hs_lvl;
      assign vid.vsync      = w_vs_lvl;
      assign vid.display_on = w_de_raw;
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0] r_hs_pipe;
      logic [PIPE_DELAY-1:0] r_vs_pipe;
      logic [PIPE_DELAY-1:0] r_de_pipe;
      logic [PIPE_DELAY:0]   w_hs_shift;
      logic [PIPE_DELAY:0]   w_vs_shift;
      logic [PIPE_DELAY:0]   w_de_shift;

      // Stage 0 takes the current raw value; the oldest stage drives the port.
      assign w_hs_shift = {r_hs_pipe, w_hs_lvl};
      assign w_vs_shift = {r_vs_pipe, w_vs_lvl};
      assign w_de_shift = {r_de_pipe, w_de_raw};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_hs_pipe <= {PIPE_DELAY{~HS_ACT}};
          r_vs_pipe <= {PIPE_DELAY{~VS_ACT}};
          r_de_pipe <= '0;
        end else if (w_pix_stb) begin
          r_hs_pipe <= w_hs_shift[PIPE_DELAY-1:0];
          r_vs_pipe <= w_vs_shift[PIPE_DELAY-1:0];
          r_de_pipe <= w_de_shift[PIPE_DELAY-1:0];
        end
      end

      assign vid.hsync      = r_hs_pipe[PIPE_DELAY-1];
      assign vid.vsync      = r_vs_pipe[PIPE_DELAY-1];
      assign vid.display_on = r_de_pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign w_line_start    = w_pix_stb & (r_pos_x == '0);
  assign vid.pix_stb     = w_pix_stb;
  assign vid.pos_x       = r_pos_x;
  assign vid.pos_y       = r_pos_y;
  assign vid.line_start  = w_line_start;
  assign vid.frame_start = w_line_start & (r_pos_y == '0);

endmodule
